// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, start-bit glitch rejection,
// parity/framing error detection and a small receive FIFO presented through
// a valid/ready handshake.
module uart_rx_fifo #(
  parameter int CLK_PER_BITS = 217,
  parameter int N_BITS       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  output logic [N_BITS-1:0] data,
  output logic              parity_err,
  output logic              frame_err,
  output logic              valid,
  input  logic              ready,
  output logic              overrun,
  output logic              busy
);

  localparam int TW = $clog2(CLK_PER_BITS) + 1;
  localparam int IW = $clog2(N_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [TW-1:0] T_HALF    = TW'((CLK_PER_BITS - 1) / 2);
  localparam logic [TW-1:0] T_BIT     = TW'(CLK_PER_BITS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_BITS - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic          PAR_ODD   = 1'(PARITY == 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_PUSH,
    S_WAIT_HI
  } state_e;

  typedef struct packed {
    logic              ferr;
    logic              perr;
    logic [N_BITS-1:0] data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_s_q;

  // Two-flop synchroniser; reset to the idle line level so no false start bit.
  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [N_BITS-1:0] shift_q, shift_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              stop_idx_q, stop_idx_d;
  logic              busy_q, busy_d;
  logic              push;

  // Next-state logic: bit timing, sampling at bit centres, error collection.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + TW'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    stop_idx_d = stop_idx_q;
    push       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (timer_q == T_HALF) begin
          timer_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;          // line went back high: glitch
          end else begin
            idx_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (timer_q == T_BIT) begin
          timer_d         = '0;
          shift_d[idx_q]  = rx_s_q;
          if (idx_q == IDX_LAST) begin
            stop_idx_d = 1'b0;
            state_d    = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PAR: begin
        if (timer_q == T_BIT) begin
          timer_d    = '0;
          perr_d     = ((^shift_q) ^ rx_s_q) != PAR_ODD;
          stop_idx_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_q == T_BIT) begin
          timer_d = '0;
          if (!rx_s_q) ferr_d = 1'b1;
          if (stop_idx_q == STOP_LAST) state_d = S_PUSH;
          else                         stop_idx_d = 1'b1;
        end
      end
      S_PUSH: begin
        timer_d = '0;
        push    = 1'b1;
        state_d = ferr_q ? S_WAIT_HI : S_IDLE;
      end
      S_WAIT_HI: begin
        timer_d = '0;
        if (rx_s_q) state_d = S_IDLE;  // hold off retriggering during a break
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // FSM state and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      stop_idx_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      stop_idx_q <= stop_idx_d;
      busy_q     <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  entry_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          full, pop, push_ok;
  entry_t        wr_entry, head;

  assign valid    = (count_q != '0);
  assign full     = (count_q == CNT_FULL);
  assign pop      = valid && ready;
  assign push_ok  = push && (!full || pop);
  assign wr_entry = {ferr_q, perr_q, shift_q};
  assign head     = mem_q[rd_ptr_q];

  // Pointer and occupancy update; a full FIFO drops the word and flags overrun.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = push && full && !pop;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // FIFO storage write.
  // NOTE: storage is deliberately not reset; stale entries are never visible
  // because the outputs below are gated by valid, which comes from reset pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign data       = valid ? head.data : '0;
  assign parity_err = valid ? head.perr : 1'b0;
  assign frame_err  = valid ? head.ferr : 1'b0;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: three instances cover the base frame
// format, even parity and two stop bits. A scoreboard queue per instance holds
// the words expected at the FIFO head.
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx;
  logic [2:0] ready;
  logic [7:0] data [3];
  logic [2:0] perr, ferr, valid, overrun, busy;

  int n_checks = 0;
  int n_errors = 0;
  int ovr_cnt [3];
  int valid_cycles [3];

  logic [9:0] exp_q0 [$];
  logic [9:0] exp_q1 [$];
  logic [9:0] exp_q2 [$];
  logic [9:0] e;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_PER_BITS(CPB), .N_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_base (
    .clk(clk), .rst(rst), .rx_in(rx[0]), .data(data[0]), .parity_err(perr[0]),
    .frame_err(ferr[0]), .valid(valid[0]), .ready(ready[0]), .overrun(overrun[0]), .busy(busy[0]));

  uart_rx_fifo #(.CLK_PER_BITS(CPB), .N_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_par (
    .clk(clk), .rst(rst), .rx_in(rx[1]), .data(data[1]), .parity_err(perr[1]),
    .frame_err(ferr[1]), .valid(valid[1]), .ready(ready[1]), .overrun(overrun[1]), .busy(busy[1]));

  uart_rx_fifo #(.CLK_PER_BITS(CPB), .N_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_stop (
    .clk(clk), .rst(rst), .rx_in(rx[2]), .data(data[2]), .parity_err(perr[2]),
    .frame_err(ferr[2]), .valid(valid[2]), .ready(ready[2]), .overrun(overrun[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard helpers
  function automatic int q_size(input int k);
    case (k)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [9:0] q_peek(input int k);
    case (k)
      0:       return exp_q0[0];
      1:       return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  task automatic q_pop(input int k);
    case (k)
      0:       void'(exp_q0.pop_front());
      1:       void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
  endtask

  task automatic expect_word(input int k, input logic [7:0] d, input logic pe, input logic fe);
    case (k)
      0:       exp_q0.push_back({fe, pe, d});
      1:       exp_q1.push_back({fe, pe, d});
      default: exp_q2.push_back({fe, pe, d});
    endcase
  endtask

  // Even parity: total count of ones across data and parity bit must be even.
  function automatic logic even_perr(input logic [7:0] d, input logic p);
    return ($countones({d, p}) % 2) != 0;
  endfunction

  // Head check at the falling edge: whatever is presented must match the front
  // of the scoreboard, which also proves the head holds while not accepted.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (overrun[k]) ovr_cnt[k]++;
        if (valid[k]) begin
          valid_cycles[k]++;
          if (q_size(k) == 0) begin
            check($sformatf("spurious_valid_%0d", k), 32'(valid[k]), 32'(0));
          end else begin
            e = q_peek(k);
            check($sformatf("data_%0d", k), 32'(data[k]), 32'(e[7:0]));
            check($sformatf("parity_err_%0d", k), 32'(perr[k]), 32'(e[8]));
            check($sformatf("frame_err_%0d", k), 32'(ferr[k]), 32'(e[9]));
          end
        end
      end
    end
  end

  // Pop on the same edge the DUT accepts the head.
  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (valid[k] && ready[k] && q_size(k) != 0) q_pop(k);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int k, input logic b);
    rx[k] = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int k, input logic [7:0] d, input logic par_en,
                            input logic par_bit, input int nstop, input logic stop2);
    drive_bit(k, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(k, d[i]);
    if (par_en) drive_bit(k, par_bit);
    drive_bit(k, 1'b1);
    if (nstop == 2) drive_bit(k, stop2);
  endtask

  task automatic wait_drain(input int k, input int budget);
    for (int i = 0; i < budget && q_size(k) != 0; i++) @(negedge clk);
    check($sformatf("drain_%0d", k), 32'(q_size(k)), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    rx    = 3'b111;
    ready = 3'b111;
    for (int k = 0; k < 3; k++) begin
      ovr_cnt[k]      = 0;
      valid_cycles[k] = 0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid_%0d", k), 32'(valid[k]), 32'(0));
      check($sformatf("rst_data_%0d", k), 32'(data[k]), 32'(0));
      check($sformatf("rst_perr_%0d", k), 32'(perr[k]), 32'(0));
      check($sformatf("rst_ferr_%0d", k), 32'(ferr[k]), 32'(0));
      check($sformatf("rst_overrun_%0d", k), 32'(overrun[k]), 32'(0));
      check($sformatf("rst_busy_%0d", k), 32'(busy[k]), 32'(0));
    end
    rst = 1'b0;
    idle(20);

    // Basic frame 0xA5, ready held high: valid for exactly one cycle
    valid_cycles[0] = 0;
    expect_word(0, 8'hA5, 1'b0, 1'b0);
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1);
    idle(8);
    check("a5_valid_cycles", 32'(valid_cycles[0]), 32'(1));
    check("a5_drained", 32'(q_size(0)), 32'(0));
    check("a5_busy_idle", 32'(busy[0]), 32'(0));

    // Start-bit glitch: 5 clocks low
    valid_cycles[0] = 0;
    rx[0] = 1'b0;
    idle(5);
    check("glitch_busy_hi", 32'(busy[0]), 32'(1));
    rx[0] = 1'b1;
    idle(30);
    check("glitch_busy_lo", 32'(busy[0]), 32'(0));
    check("glitch_no_valid", 32'(valid_cycles[0]), 32'(0));

    // Even parity: 0x03 with parity bit 0, then with parity bit 1
    expect_word(1, 8'h03, even_perr(8'h03, 1'b0), 1'b0);
    send_frame(1, 8'h03, 1'b1, 1'b0, 1, 1'b1);
    idle(8);
    expect_word(1, 8'h03, even_perr(8'h03, 1'b1), 1'b0);
    send_frame(1, 8'h03, 1'b1, 1'b1, 1, 1'b1);
    idle(8);
    wait_drain(1, 50);

    // Two stop bits: second stop low then break, then a clean frame
    valid_cycles[2] = 0;
    expect_word(2, 8'h5A, 1'b0, 1'b1);
    send_frame(2, 8'h5A, 1'b0, 1'b0, 2, 1'b0);
    idle(40);
    check("break_busy_hi", 32'(busy[2]), 32'(1));
    check("break_one_word", 32'(valid_cycles[2]), 32'(1));
    rx[2] = 1'b1;
    idle(2 * CPB);
    check("break_busy_lo", 32'(busy[2]), 32'(0));
    expect_word(2, 8'h11, 1'b0, 1'b0);
    send_frame(2, 8'h11, 1'b0, 1'b0, 2, 1'b1);
    idle(8);
    wait_drain(2, 50);
    check("break_total_words", 32'(valid_cycles[2]), 32'(2));

    // Overflow: ready low, five back-to-back frames into a 4-deep FIFO
    ready[0] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expect_word(0, 8'(i), 1'b0, 1'b0);
      send_frame(0, 8'(i), 1'b0, 1'b0, 1, 1'b1);
    end
    check("ovr_before5", 32'(ovr_cnt[0]), 32'(0));
    send_frame(0, 8'h05, 1'b0, 1'b0, 1, 1'b1);
    idle(8);
    check("ovr_after5", 32'(ovr_cnt[0]), 32'(1));
    ready[0] = 1'b1;
    wait_drain(0, 50);
    idle(2);
    check("ovr_empty", 32'(valid[0]), 32'(0));

    // Reset mid-frame with a word parked in the FIFO
    ready[0] = 1'b0;
    expect_word(0, 8'h3C, 1'b0, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1);
    idle(8);
    check("rst_pre_valid", 32'(valid[0]), 32'(1));
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'(8'h55 >> i));
    rx[0] = 1'b0;
    idle(8);
    check("rst_pre_busy", 32'(busy[0]), 32'(1));
    #2 rst = 1'b1;
    exp_q0.delete();
    #1;
    check("rst_async_valid", 32'(valid[0]), 32'(0));
    check("rst_async_data", 32'(data[0]), 32'(0));
    check("rst_async_busy", 32'(busy[0]), 32'(0));
    check("rst_async_ferr", 32'(ferr[0]), 32'(0));
    rx[0] = 1'b1;
    idle(3);
    rst = 1'b0;
    ready[0] = 1'b1;
    valid_cycles[0] = 0;
    idle(CPB);
    expect_word(0, 8'hC3, 1'b0, 1'b0);
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1, 1'b1);
    idle(8);
    wait_drain(0, 50);
    idle(CPB);
    check("rst_one_word", 32'(valid_cycles[0]), 32'(1));

    check("ovr_total_par", 32'(ovr_cnt[1]), 32'(0));
    check("ovr_total_stop", 32'(ovr_cnt[2]), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the team's single-word UART receiver.
- Adds configurable frame format: data bits, parity mode, stop bits.
- Adds an input synchroniser, glitch rejection on the start bit, parity and framing error detection, and a small receive FIFO with valid/ready output handshake.
- Sits between the board RX pin and any byte consumer, such as a command parser.

Parameters:
- CLK_PER_BITS, 217: clocks per bit period; minimum 4.
- N_BITS, 8: data bits per frame; range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: receive FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1: system clock; all logic is on its rising edge.
- rst  in  1: reset; asynchronous, active-high.
- rx_in  in  1: serial line, asynchronous to clk; idles high.
- data  out  N_BITS: FIFO head data word; LSB was received first.
- parity_err  out  1: parity error flag of the head word; always 0 when PARITY=0.
- frame_err  out  1: framing error flag of the head word (a stop bit sampled low).
- valid  out  1: FIFO non-empty; head is presented on data/flags.
- ready  in  1: consumer accepts the head when valid && ready at a clk edge.
- overrun  out  1: one-cycle pulse when a completed word is dropped because the FIFO is full.
- busy  out  1: high in every state except IDLE.

Behaviour:
- Reset (async assert, any state, including mid-frame):
  - Synchroniser flops set to 1; FSM goes to IDLE; timer, bit index and FIFO pointers cleared.
  - Outputs: valid=0, data=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - Any partial frame is discarded.
- Synchroniser: two flops on rx_in, giving rx_s. All FSM decisions use rx_s, so there is 2 cycles of latency from the pin.
- timer width is $clog2(CLK_PER_BITS)+1. timer is cleared at every state entry and at every bit boundary.
- FSM states: IDLE, START, DATA, PAR, STOP, PUSH, WAIT_HI.
  - IDLE: when rx_s=0, go to START with timer=0.
  - START: count until timer==(CLK_PER_BITS-1)/2.
    - If rx_s=1 there: glitch; return to IDLE. No error, no push.
    - Else: clear timer, index=0, go to DATA.
  - DATA: when timer==CLK_PER_BITS-1, sample rx_s into shift[index] and clear timer.
    - After the sample with index==N_BITS-1: go to PAR if PARITY!=0, else to STOP.
    - Otherwise index increments.
  - PAR: sample at timer==CLK_PER_BITS-1.
    - perr = (XOR of data bits XOR sampled bit) != (PARITY==1 ? 1 : 0).
    - Equivalently: odd parity requires an odd total count of ones across data and parity; even parity requires an even total.
  - STOP: sample STOP_BITS bits at successive bit centres. ferr is set if any stop sample is 0. After the last stop sample, go to PUSH.
  - PUSH: one cycle. Write {ferr, perr, shift} into the FIFO.
    - If ferr: go to WAIT_HI, else go to IDLE.
  - WAIT_HI: stay until rx_s=1, then go to IDLE. This prevents a break condition from retriggering frames.
- Latency: valid rises 1 cycle after the PUSH cycle, when the FIFO was empty.
- FIFO:
  - Registered storage; head word is driven from storage, with no fall-through within a cycle.
  - Pop occurs on valid && ready.
  - Push in PUSH state when not full, or when full with a simultaneous pop. Push and pop in the same cycle are both accepted and the count is unchanged.
  - Push when full and no pop: the word is dropped, overrun=1 for exactly that cycle, and existing contents are unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH. count width is $clog2(FIFO_DEPTH)+1.
- data and the flags hold stable while valid && !ready.
- Back-to-back frames: a new start bit that is low immediately after STOP → PUSH → IDLE must be caught.
  - The end of frame precedes the next start edge by at least half a bit, so there is no loss.

Test Plan:
- Test-bench settings: CLK_PER_BITS=16, N_BITS=8, PARITY=0, STOP_BITS=1, ready=1.
  - Stimulus: frame 0xA5.
  - Required response: valid high 1 cycle carrying data=0xA5, both flags 0.
- Start-bit glitch:
  - Stimulus: drive rx_in low for 5 clocks, then high.
  - Required response: busy returns to 0, no valid, no error.
- PARITY=2 (even):
  - Stimulus: send 0x03 with parity bit 0, then 0x03 with parity bit 1.
  - Required response: parity_err = 0 on the first word, 1 on the second.
- STOP_BITS=2:
  - Stimulus: 0x5A with the second stop bit low, then the line held low for 40 clocks, then high.
  - Required response: one word with frame_err=1. No further words until the line returns high. The next valid frame 0x11 is received cleanly.
- Overflow:
  - Setup: FIFO_DEPTH=4, ready=0.
  - Stimulus: send 0x01..0x05.
  - Required response: overrun pulses once, on 0x05. Then raise ready; the words read out are 0x01, 0x02, 0x03, 0x04.
- Reset mid-frame:
  - Stimulus: assert rst during DATA bit 3, then release and send 0xC3.
  - Required response: outputs go to 0 immediately on assert (asynchronous). Exactly one word, 0xC3, is received.
